// File: rtl/softmax_argmax_stream_if.sv
// rtl/softmax_argmax_stream_if.sv - score-in / result-out handshake bundle for softmax_argmax_stream
interface softmax_argmax_stream_if #(
  parameter int IN_WIDTH  = 4,
  parameter int IDX_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_WIDTH-1:0] out_index;
  logic [IN_WIDTH-1:0]  out_max;
  logic                 out_tie;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_index, out_max, out_tie
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_index, out_max, out_tie
  );
endinterface

// File: rtl/softmax_argmax_stream.sv
// rtl/softmax_argmax_stream.sv - serial running-max classifier: one score per beat, result held per frame
module softmax_argmax_stream #(
  parameter int IN_WIDTH    = 4,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4,
  parameter int SIGNED_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  softmax_argmax_stream_if.slave  bus
);
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] OUT   = 1'b1;
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);

  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] count;
  logic [IDX_WIDTH-1:0] idx_q;
  logic [IN_WIDTH-1:0]  max_q;
  logic                 tie_q;
  logic                 greater;

  always_comb begin
    greater = 1'b0;
    if (SIGNED_MODE != 0) greater = $signed(bus.in_data) > $signed(max_q);
    else                  greater = bus.in_data > max_q;
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == OUT);
  assign bus.out_index = idx_q;
  assign bus.out_max   = max_q;
  assign bus.out_tie   = tie_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ACCUM;
      count <= '0;
      idx_q <= '0;
      max_q <= '0;
      tie_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.in_valid) begin
            // Class 0 seeds the frame; later equal scores only flag a tie so the lowest index wins.
            if (count == '0) begin
              max_q <= bus.in_data;
              idx_q <= '0;
              tie_q <= 1'b0;
            end else if (greater) begin
              max_q <= bus.in_data;
              idx_q <= count;
              tie_q <= 1'b0;
            end else if (bus.in_data == max_q) begin
              tie_q <= 1'b1;
            end
            if (count == LAST) begin
              count <= '0;
              state <= OUT;
            end else begin
              count <= count + IDX_WIDTH'(1);
            end
          end
        end
        default: begin
          if (bus.out_ready) state <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_argmax_stream.sv
// tb/tb_softmax_argmax_stream.sv - directed table-driven bench for softmax_argmax_stream
module tb_softmax_argmax_stream;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       iv [3];
  logic [3:0] id [3];
  logic       ordy [3];
  logic       ir [3];
  logic       ov [3];
  logic       ot [3];
  logic [3:0] oi [3];
  logic [3:0] om [3];

  softmax_argmax_stream_if #(.IN_WIDTH(4), .IDX_WIDTH(4)) ifa ();
  softmax_argmax_stream_if #(.IN_WIDTH(4), .IDX_WIDTH(4)) ifs ();
  softmax_argmax_stream_if #(.IN_WIDTH(4), .IDX_WIDTH(4)) ifw ();

  softmax_argmax_stream #(.IN_WIDTH(4), .NUM_CLASSES(10), .IDX_WIDTH(4), .SIGNED_MODE(0))
    dut_u (.clk(clk), .reset_n(reset_n), .bus(ifa));
  softmax_argmax_stream #(.IN_WIDTH(4), .NUM_CLASSES(10), .IDX_WIDTH(4), .SIGNED_MODE(1))
    dut_s (.clk(clk), .reset_n(reset_n), .bus(ifs));
  softmax_argmax_stream #(.IN_WIDTH(4), .NUM_CLASSES(16), .IDX_WIDTH(4), .SIGNED_MODE(0))
    dut_w (.clk(clk), .reset_n(reset_n), .bus(ifw));

  assign ifa.in_valid = iv[0];  assign ifa.in_data = id[0];  assign ifa.out_ready = ordy[0];
  assign ifs.in_valid = iv[1];  assign ifs.in_data = id[1];  assign ifs.out_ready = ordy[1];
  assign ifw.in_valid = iv[2];  assign ifw.in_data = id[2];  assign ifw.out_ready = ordy[2];
  assign ir[0] = ifa.in_ready;  assign ov[0] = ifa.out_valid; assign ot[0] = ifa.out_tie;
  assign oi[0] = ifa.out_index; assign om[0] = ifa.out_max;
  assign ir[1] = ifs.in_ready;  assign ov[1] = ifs.out_valid; assign ot[1] = ifs.out_tie;
  assign oi[1] = ifs.out_index; assign om[1] = ifs.out_max;
  assign ir[2] = ifw.in_ready;  assign ov[2] = ifw.out_valid; assign ot[2] = ifw.out_tie;
  assign oi[2] = ifw.out_index; assign om[2] = ifw.out_max;

  typedef struct {
    int          dut;
    logic [63:0] beats;
    int          eidx;
    int          emax;
    int          etie;
  } vec_t;

  vec_t vt [8];
  int checks = 0;
  int failures = 0;

  function automatic logic [63:0] mk(input int b0, input int b1, input int b2, input int b3,
                                     input int b4, input int b5, input int b6, input int b7,
                                     input int b8, input int b9);
    mk = {24'd0, 4'(b9), 4'(b8), 4'(b7), 4'(b6), 4'(b5), 4'(b4), 4'(b3), 4'(b2), 4'(b1), 4'(b0)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Beats are presented at the falling edge; a beat is taken on the following rising edge.
  task automatic send_beats(input int d, input string tag, input logic [63:0] beats,
                            input int first, input int n, input int maxgap);
    int g;
    for (int k = first; k < n; k++) begin
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin
        iv[d] = 1'b0;
        @(negedge clk);
      end
      iv[d] = 1'b1;
      id[d] = beats[4*k +: 4];
      if (k == n - 1) check({tag, " valid_before_last"}, int'(ov[d]), 0);
      @(negedge clk);
    end
    iv[d] = 1'b0;
  endtask

  task automatic check_result(input int d, input string tag, input int eidx, input int emax,
                              input int etie);
    check({tag, " out_valid"}, int'(ov[d]), 1);
    check({tag, " in_ready_out"}, int'(ir[d]), 0);
    check({tag, " out_index"}, int'(oi[d]), eidx);
    check({tag, " out_max"}, int'(om[d]), emax);
    check({tag, " out_tie"}, int'(ot[d]), etie);
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    check({tag, " out_valid_drop"}, int'(ov[d]), 0);
    check({tag, " in_ready_back"}, int'(ir[d]), 1);
  endtask

  initial begin
    logic [63:0] wide;
    logic [63:0] held;
    string tag;

    vt[0] = '{0, mk(1,0,0,0,0,0,0,0,0,0), 0, 1, 0};
    vt[1] = '{0, mk(0,0,0,0,0,0,0,0,2,1), 8, 2, 0};
    vt[2] = '{0, mk(12,12,0,3,4,15,3,4,2,1), 5, 15, 0};
    vt[3] = '{0, mk(3,7,7,0,0,0,0,0,0,0), 1, 7, 1};
    vt[4] = '{0, mk(7,7,9,0,0,0,0,0,0,0), 2, 9, 0};
    vt[5] = '{0, mk(15,1,8,0,0,0,0,0,0,0), 0, 15, 0};
    vt[6] = '{1, mk(15,1,8,0,0,0,0,0,0,0), 1, 1, 0};
    vt[7] = '{1, mk(8,8,8,8,13,8,8,8,8,8), 4, 13, 0};

    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0;
      id[d] = 4'd0;
      ordy[d] = 1'b0;
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      tag = $sformatf("reset_d%0d", d);
      check({tag, " in_ready"}, int'(ir[d]), 1);
      check({tag, " out_valid"}, int'(ov[d]), 0);
      check({tag, " out_index"}, int'(oi[d]), 0);
      check({tag, " out_max"}, int'(om[d]), 0);
      check({tag, " out_tie"}, int'(ot[d]), 0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Pass 0 is gap-free, pass 1 inserts random in_valid gaps; results must match.
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v < 8; v++) begin
        tag = $sformatf("vec%0d_pass%0d", v, pass);
        send_beats(vt[v].dut, tag, vt[v].beats, 0, 10, pass * 3);
        check_result(vt[v].dut, tag, vt[v].eidx, vt[v].emax, vt[v].etie);
      end
    end

    // Back-pressure: result held, pending beat not consumed until OUT is left.
    send_beats(0, "bp", vt[2].beats, 0, 10, 0);
    iv[0] = 1'b1;
    id[0] = 4'd9;
    for (int c = 0; c < 5; c++) begin
      tag = $sformatf("bp_hold%0d", c);
      check({tag, " out_valid"}, int'(ov[0]), 1);
      check({tag, " in_ready"}, int'(ir[0]), 0);
      check({tag, " out_index"}, int'(oi[0]), 5);
      check({tag, " out_max"}, int'(om[0]), 15);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    check("bp_release out_valid", int'(ov[0]), 0);
    check("bp_release in_ready", int'(ir[0]), 1);
    @(negedge clk);
    held = mk(9,0,0,0,0,0,0,0,0,0);
    send_beats(0, "bp_next", held, 1, 10, 0);
    check_result(0, "bp_next", 0, 9, 0);

    // Reset mid-frame discards the partial frame.
    send_beats(0, "rst_partial", vt[2].beats, 0, 6, 0);
    reset_n = 1'b0;
    #1;
    check("rst_mid in_ready", int'(ir[0]), 1);
    check("rst_mid out_valid", int'(ov[0]), 0);
    check("rst_mid out_max", int'(om[0]), 0);
    check("rst_mid out_index", int'(oi[0]), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_beats(0, "rst_after", vt[1].beats, 0, 10, 0);
    check_result(0, "rst_after", 8, 2, 0);

    // 16 classes: max at the last index, then the wrapped counter starts a fresh frame.
    for (int k = 0; k < 16; k++) wide[4*k +: 4] = 4'(k);
    send_beats(2, "wide0", wide, 0, 16, 0);
    check_result(2, "wide0", 15, 15, 0);
    wide = '0;
    wide[3:0] = 4'd5;
    wide[15:12] = 4'd5;
    send_beats(2, "wide1", wide, 0, 16, 2);
    check_result(2, "wide1", 0, 5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
